// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V size codes, FSM state
// encoding, default memory word-address width and request classification.
package lsu_pkg;

  // Default word-address width of the attached data memory (64 words)
  localparam int LSU_ADDR_W = 6;

  // RISC-V funct3 size codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // Stores only know the signed size codes; loads add the unsigned variants
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords must sit on an even byte, words on a multiple of four
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data path of the load/store unit: picks the addressed
// byte/halfword out of a memory word (with sign or zero extension) and merges
// store data into the addressed lanes of a word. Little-endian lanes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load extraction: halfword lane comes from addr[1] only, so addr[0] is ignored
  always_comb begin
    byte_sel  = rdata[{byte_off, 3'b000} +: 8];
    half_sel  = byte_off[1] ? rdata[31:16] : rdata[15:0];
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // Store merge: untouched lanes keep the word just read from memory
  always_comb begin
    store_word = rdata;
    case (funct3)
      F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-word data memory.
// Loads read one word; word stores write directly; byte/halfword stores do a
// read-modify-write of the addressed word. Illegal size codes answer with an
// error and no memory traffic.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// are rejected with an error instead of having their low address bits ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state;
  logic        cap_write;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_off;
  logic [31:0] cap_wdata;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        misaligned;
  logic        unused_addr_bits;

  assign req_ready        = (state == S_IDLE);
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = addr_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (cap_funct3),
    .byte_off   (cap_off),
    .rdata      (mem_rdata),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Access sequencer; memory strobes and response are registered so reset drops them at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cap_write  <= 1'b0;
      cap_funct3 <= 3'b000;
      cap_off    <= 2'b00;
      cap_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
            cap_off    <= req_addr[1:0];
            cap_wdata  <= req_wdata;
            if (!funct3_legal(req_write, req_funct3) || misaligned) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (req_write && (req_funct3 == F3_W)) begin
                state     <= S_WR;
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state    <= S_RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        S_RD: begin
          mem_read <= 1'b0;
          if (cap_write) begin
            state     <= S_WR;
            mem_write <= 1'b1;
            mem_wdata <= store_word;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        S_WR: begin
          mem_write  <= 1'b0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 64-word behavioural memory.
module tb_load_store_unit;

  localparam int ADDR_W = 6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [64];
  logic        init_mem = 1'b1;

  int checks = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  int both_cnt = 0;
  int rd0 = 0;
  int wr0 = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory reads combinationally, writes at the rising edge, preloads while init_mem is high
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h11223344;
      mem[3] <= 32'h8899AABB;
      mem[4] <= 32'hCAFEF00D;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Running totals of memory cycles and responses seen at clock edges
  always @(posedge clk) begin
    if (mem_read)   rd_cnt   <= rd_cnt + 1;
    if (mem_write)  wr_cnt   <= wr_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Read and write strobes must never overlap
  always @(negedge clk) begin
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present one request at a falling edge; it is accepted at the next rising edge
  task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic hold);
    @(negedge clk);
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Latency counts falling edges after the acceptance edge; 99 means no response in time
  task automatic waitResponse(output int lat, output logic [31:0] rdata, output logic err,
                              output logic after);
    logic done;
    done  = 1'b0;
    lat   = 99;
    rdata = 32'h0;
    err   = 1'b0;
    after = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (!done) begin
        @(negedge clk);
        if (resp_valid) begin
          done  = 1'b1;
          lat   = i;
          rdata = resp_rdata;
          err   = resp_err;
        end
      end
    end
    if (done) begin
      @(negedge clk);
      after = resp_valid;
    end
  endtask

  task automatic runAccess(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int exp_rd, input int exp_wr);
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        after;
    applyStimulus(w, f3, addr, wdata, 1'b0);
    waitResponse(lat, rdata, err, after);
    checkOutput({tag, ".latency"}, lat, exp_lat);
    checkOutput({tag, ".rdata"}, rdata, exp_rdata);
    checkOutput({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
    checkOutput({tag, ".pulse"}, {31'h0, after}, 32'h0);
    checkOutput({tag, ".reads"}, rd_cnt - rd0, exp_rd);
    checkOutput({tag, ".writes"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    int          resp0;
    int          lat;
    logic [31:0] rdata;
    logic        done;

    // Asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    checkOutput("reset.ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset.resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("reset.resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset.resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("reset.mem_read", {31'h0, mem_read}, 32'h0);
    checkOutput("reset.mem_write", {31'h0, mem_write}, 32'h0);
    checkOutput("reset.mem_addr", {26'h0, mem_addr}, 32'h0);
    checkOutput("reset.mem_wdata", mem_wdata, 32'h0);

    @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("release.ready", {31'h0, req_ready}, 32'h1);

    // Loads from mem[3]=8899AABB and mem[1]=11223344
    runAccess("lb_0d",  1'b0, F3_B,  32'h0D, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    runAccess("lbu_0d", 1'b0, F3_BU, 32'h0D, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
    runAccess("lh_0e",  1'b0, F3_H,  32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
    runAccess("lhu_0c", 1'b0, F3_HU, 32'h0C, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0);
    runAccess("lbu_0f", 1'b0, F3_BU, 32'h0F, 32'h0, 32'h00000088, 1'b0, 2, 1, 0);
    runAccess("lw_04",  1'b0, F3_W,  32'h04, 32'h0, 32'h11223344, 1'b0, 2, 1, 0);
    runAccess("lw_hiaddr", 1'b0, F3_W, 32'hFFFFFF0C, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);

    // Stores: halfword read-modify-write, word direct write, byte into top lane
    runAccess("sh_06", 1'b1, F3_H, 32'h06, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1);
    checkOutput("sh_06.mem1", mem[1], 32'hBEEF3344);
    runAccess("sw_08", 1'b1, F3_W, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    checkOutput("sw_08.mem2", mem[2], 32'hDEADBEEF);
    runAccess("sb_0b", 1'b1, F3_B, 32'h0B, 32'h12345677, 32'h0, 1'b0, 3, 1, 1);
    checkOutput("sb_0b.mem2", mem[2], 32'h77ADBEEF);
    checkOutput("sb_0b.mem1", mem[1], 32'hBEEF3344);

    // Misaligned accesses depend on the trap build option
`ifdef LSU_MISALIGN_TRAP_EN
    runAccess("lw_06", 1'b0, F3_W, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    runAccess("lh_07", 1'b0, F3_H, 32'h07, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
    runAccess("lw_06", 1'b0, F3_W, 32'h06, 32'h0, 32'hBEEF3344, 1'b0, 2, 1, 0);
    runAccess("lh_07", 1'b0, F3_H, 32'h07, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1, 0);
`endif

    // Illegal size codes: error response, no memory traffic, result held afterwards
    runAccess("ld_011", 1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ld_011.err_held", {31'h0, resp_err}, 32'h1);
    checkOutput("ld_011.rdata_held", resp_rdata, 32'h0);
    runAccess("st_100", 1'b1, 3'b100, 32'h08, 32'h000000FF, 32'h0, 1'b1, 1, 0, 0);
    checkOutput("st_100.mem2", mem[2], 32'h77ADBEEF);

    // Request held high while busy with a changed address must not be taken again
    resp0 = resp_cnt;
    applyStimulus(1'b0, F3_W, 32'h0C, 32'h0, 1'b1);
    req_addr = 32'h04;
    @(negedge clk);
    checkOutput("b2b.ready_busy", {31'h0, req_ready}, 32'h0);
    done = resp_valid;
    lat = 1;
    rdata = resp_rdata;
    for (int i = 2; i <= 8; i++) begin
      if (!done) begin
        @(negedge clk);
        if (resp_valid) begin
          done = 1'b1;
          lat = i;
          rdata = resp_rdata;
        end
      end
    end
    req_valid = 1'b0;
    if (!done) lat = 99;
    repeat (3) @(negedge clk);
    checkOutput("b2b.latency", lat, 2);
    checkOutput("b2b.rdata", rdata, 32'h8899AABB);
    checkOutput("b2b.reads", rd_cnt - rd0, 1);
    checkOutput("b2b.responses", resp_cnt - resp0, 1);

    // Reset while a byte store is in its write cycle drops the write and the response
    applyStimulus(1'b1, F3_B, 32'h11, 32'h00000055, 1'b0);
    resp0 = resp_cnt;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstwr.mem_write", {31'h0, mem_write}, 32'h1);
    checkOutput("rstwr.mem_wdata", mem_wdata, 32'hCAFE550D);
    rst = 1'b1;
    #1;
    checkOutput("rstwr.mem_write_off", {31'h0, mem_write}, 32'h0);
    checkOutput("rstwr.mem_wdata_clr", mem_wdata, 32'h0);
    checkOutput("rstwr.mem_addr_clr", {26'h0, mem_addr}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstwr.ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("rstwr.responses", resp_cnt - resp0, 0);
    checkOutput("rstwr.mem4", mem[4], 32'hCAFEF00D);
    runAccess("lw_10", 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0);

    checkOutput("no_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
